// File: rtl/mem_if_pkg.sv
// Shared constants for the miniSRC memory interface sequencer.
// State encoding and latency counter sizing.
package mem_if_pkg;

    localparam int LAT_MAX = 15;
    localparam int CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/register_gen.sv
// Generic enabled register with asynchronous clear.
// Used for both MAR and MDR.
module register_gen #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_interface_seq.sv
// MAR/MDR memory interface sequencer for the miniSRC datapath.
// Drives a synchronous RAM with configurable latency and signals completion.
module mem_interface_seq
    import mem_if_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 9,
    parameter int READ_LAT  = 1,
    parameter int WRITE_LAT = 1
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] busMuxOut,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              memRead,
    input  logic              memWrite,
    output logic [DATA_W-1:0] mdr_q,
    output logic [ADDR_W-1:0] mar_q,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rden,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (READ_LAT < 1 || READ_LAT > LAT_MAX) begin : g_bad_read_lat
        $error("mem_interface_seq: READ_LAT must be 1..15");
    end
    if (WRITE_LAT < 1 || WRITE_LAT > LAT_MAX) begin : g_bad_write_lat
        $error("mem_interface_seq: WRITE_LAT must be 1..15");
    end

    // Reads hold one extra cycle so the RAM q is valid at capture.
    localparam logic [CNT_W-1:0] RD_INIT = CNT_W'(READ_LAT);
    localparam logic [CNT_W-1:0] WR_INIT = CNT_W'(WRITE_LAT - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] next_count;

    logic idle;
    logic cnt_zero;
    logic capture;
    logic viol;
    logic mar_en;
    logic mdr_en;
    logic [DATA_W-1:0] mdr_d;

    assign idle     = (state == IDLE);
    assign cnt_zero = (count == '0);
    assign capture  = (state == RD) && cnt_zero;
    assign viol     = idle ? (memRead && memWrite)
                           : (memRead || memWrite);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= IDLE;
            count <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= next_state;
            count <= next_count;
            done  <= (next_state == DONE);
            err   <= viol;
        end
    end

    always_comb begin
        next_state = state;
        next_count = count;
        unique case (state)
            IDLE: begin
                if (memRead && !memWrite) begin
                    next_state = RD;
                    next_count = RD_INIT;
                end else if (memWrite && !memRead) begin
                    next_state = WR;
                    next_count = WR_INIT;
                end
            end
            RD, WR: begin
                if (cnt_zero) begin
                    next_state = DONE;
                end else begin
                    next_count = count - 1'b1;
                end
            end
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        mem_rden = 1'b0;
        mem_wren = 1'b0;
        unique case (state)
            IDLE: ;
            RD: begin
                busy     = 1'b1;
                mem_rden = 1'b1;
            end
            WR: begin
                busy     = 1'b1;
                mem_wren = 1'b1;
            end
            DONE: busy = 1'b1;
            default: ;
        endcase
    end

    assign mar_en = idle && MARin;
    assign mdr_en = (idle && MDRin) || capture;
    assign mdr_d  = capture ? mem_rdata : busMuxOut;

    register_gen #(.W(ADDR_W)) u_mar (
        .clock (clock),
        .clear (clear),
        .en    (mar_en),
        .d     (busMuxOut[ADDR_W-1:0]),
        .q     (mar_q)
    );

    register_gen #(.W(DATA_W)) u_mdr (
        .clock (clock),
        .clear (clear),
        .en    (mdr_en),
        .d     (mdr_d),
        .q     (mdr_q)
    );

    assign mem_addr  = mar_q;
    assign mem_wdata = mdr_q;

endmodule

// File: tb/tb_mem_interface_seq.sv
// Bench for mem_interface_seq: two instances with different latencies
// share one stimulus stream and are compared against a transaction model.
module tb_mem_interface_seq;

    logic        clk;
    logic        clear;
    logic [31:0] bus;
    logic        mar_in;
    logic        mdr_in;
    logic        rd;
    logic        wr;

    logic [31:0] mdr   [2];
    logic [8:0]  mar   [2];
    logic [8:0]  addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic [1:0]  busy;
    logic [1:0]  done;
    logic [1:0]  err;
    logic [1:0]  rden;
    logic [1:0]  wren;

    logic [31:0] ram [2][512];
    logic        pl_en;
    logic [8:0]  pl_addr;
    logic [31:0] pl_data;

    int RL [2] = '{1, 3};
    int WL [2] = '{4, 1};

    int checks = 0;
    int failures = 0;

    logic [8:0]  exp_mar;
    logic [31:0] exp_mdr;
    logic [31:0] ref_mem [int];
    int          waddrs [$];

    int n_rd [2], n_wr [2], n_busy [2], n_done [2];
    int t_done [2], n_err [2], n_bad [2];

    mem_interface_seq #(.READ_LAT(1), .WRITE_LAT(4)) u_a (
        .clock(clk), .clear(clear), .busMuxOut(bus),
        .MARin(mar_in), .MDRin(mdr_in),
        .memRead(rd), .memWrite(wr),
        .mdr_q(mdr[0]), .mar_q(mar[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0]),
        .mem_addr(addr[0]), .mem_wdata(wdata[0]),
        .mem_rden(rden[0]), .mem_wren(wren[0]),
        .mem_rdata(rdata[0])
    );

    mem_interface_seq #(.READ_LAT(3), .WRITE_LAT(1)) u_b (
        .clock(clk), .clear(clear), .busMuxOut(bus),
        .MARin(mar_in), .MDRin(mdr_in),
        .memRead(rd), .memWrite(wr),
        .mdr_q(mdr[1]), .mar_q(mar[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1]),
        .mem_addr(addr[1]), .mem_wdata(wdata[1]),
        .mem_rden(rden[1]), .mem_wren(wren[1]),
        .mem_rdata(rdata[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM per instance, one-cycle q latency, plus a backdoor.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (pl_en) begin
                ram[i][pl_addr] <= pl_data;
            end else if (wren[i]) begin
                ram[i][addr[i]] <= wdata[i];
            end
            rdata[i] <= ram[i][addr[i]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [8:0] a, input logic [31:0] d);
        pl_en = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
        ref_mem[int'(a)] = d;
        waddrs.push_back(int'(a));
    endtask

    task automatic load(input logic [31:0] b, input logic m, input logic d);
        bus = b;
        mar_in = m;
        mdr_in = d;
        @(posedge clk);
        #1;
        mar_in = 1'b0;
        mdr_in = 1'b0;
        if (m) exp_mar = b[8:0];
        if (d) exp_mdr = b;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("load_mar%0d", i), 32'(mar[i]), 32'(exp_mar));
            chk($sformatf("load_mdr%0d", i), mdr[i], exp_mdr);
        end
    endtask

    task automatic run_op(input logic r, input logic w, input bit inj);
        int e_rd, e_wr, e_busy, e_done, e_t, e_err;
        for (int i = 0; i < 2; i++) begin
            n_rd[i] = 0; n_wr[i] = 0; n_busy[i] = 0; n_done[i] = 0;
            t_done[i] = 0; n_err[i] = 0; n_bad[i] = 0;
        end
        rd = r;
        wr = w;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            rd = 1'b0;
            wr = 1'b0;
            mar_in = 1'b0;
            mdr_in = 1'b0;
            if (inj && c == 1) begin
                bus = 32'h0000_00AA;
                mar_in = 1'b1;
                wr = 1'b1;
            end
            if (inj && c == 2) begin
                bus = 32'hFFFF_FFFF;
                mdr_in = 1'b1;
            end
            for (int i = 0; i < 2; i++) begin
                if (rden[i]) n_rd[i]++;
                if (wren[i]) n_wr[i]++;
                if (busy[i]) n_busy[i]++;
                if (err[i]) n_err[i]++;
                if (done[i]) begin
                    n_done[i]++;
                    t_done[i] = c;
                end
                if (rden[i] && wren[i]) n_bad[i]++;
                if (mar[i] !== exp_mar || addr[i] !== exp_mar) n_bad[i]++;
                if (wren[i] && wdata[i] !== exp_mdr) n_bad[i]++;
            end
        end
        for (int i = 0; i < 2; i++) begin
            e_rd = 0; e_wr = 0; e_busy = 0; e_done = 0; e_t = 0;
            e_err = inj ? 1 : 0;
            if (r && w) begin
                e_err = 1;
            end else if (r) begin
                e_rd = RL[i] + 1;
                e_busy = RL[i] + 2;
                e_done = 1;
                e_t = RL[i] + 2;
            end else if (w) begin
                e_wr = WL[i];
                e_busy = WL[i] + 1;
                e_done = 1;
                e_t = WL[i] + 1;
            end
            chk($sformatf("rden_cycles%0d", i), 32'(n_rd[i]), 32'(e_rd));
            chk($sformatf("wren_cycles%0d", i), 32'(n_wr[i]), 32'(e_wr));
            chk($sformatf("busy_cycles%0d", i), 32'(n_busy[i]), 32'(e_busy));
            chk($sformatf("done_count%0d", i), 32'(n_done[i]), 32'(e_done));
            chk($sformatf("done_time%0d", i), 32'(t_done[i]), 32'(e_t));
            chk($sformatf("err_count%0d", i), 32'(n_err[i]), 32'(e_err));
            chk($sformatf("bus_hazard%0d", i), 32'(n_bad[i]), 32'd0);
        end
        if (r && !w) exp_mdr = ref_mem[int'(exp_mar)];
        if (w && !r) begin
            ref_mem[int'(exp_mar)] = exp_mdr;
            waddrs.push_back(int'(exp_mar));
        end
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("end_mdr%0d", i), mdr[i], exp_mdr);
            chk($sformatf("end_mar%0d", i), 32'(mar[i]), 32'(exp_mar));
        end
    endtask

    initial begin
        logic [8:0]  a;
        logic [31:0] d;
        clear = 1'b1;
        bus = '0;
        mar_in = 1'b0;
        mdr_in = 1'b0;
        rd = 1'b0;
        wr = 1'b0;
        pl_en = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        exp_mar = '0;
        exp_mdr = '0;

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_mar%0d", i), 32'(mar[i]), 32'd0);
            chk($sformatf("rst_mdr%0d", i), mdr[i], 32'd0);
            chk($sformatf("rst_flags%0d", i),
                32'({busy[i], done[i], err[i], rden[i], wren[i]}), 32'd0);
        end
        clear = 1'b0;

        // Single-cycle read of a preloaded word
        preload(9'h055, 32'hDEAD_BEEF);
        load(32'h0000_0055, 1'b1, 1'b0);
        run_op(1'b1, 1'b0, 1'b0);
        chk("read_deadbeef", mdr[0], 32'hDEAD_BEEF);

        // Long write to the top address, then read it back
        load(32'h0000_01FF, 1'b1, 1'b0);
        load(32'h1234_5678, 1'b0, 1'b1);
        run_op(1'b0, 1'b1, 1'b0);
        chk("ram_a_1ff", ram[0][9'h1FF], 32'h1234_5678);
        chk("ram_b_1ff", ram[1][9'h1FF], 32'h1234_5678);
        load(32'h0000_0000, 1'b0, 1'b1);
        run_op(1'b1, 1'b0, 1'b0);

        // Simultaneous read and write requests
        run_op(1'b1, 1'b1, 1'b0);

        // Register loads and a write request while a read is in flight
        load(32'h0000_0055, 1'b1, 1'b0);
        run_op(1'b1, 1'b0, 1'b1);
        chk("inj_mdr_not_ones", mdr[1], 32'hDEAD_BEEF);

        for (int n = 0; n < 10; n++) begin
            if ($urandom_range(1, 0) == 0) begin
                a = 9'($urandom_range(511, 0));
                d = $urandom;
                load({d[31:9], a}, 1'b1, 1'b1);
                run_op(1'b0, 1'b1, 1'b0);
            end else begin
                a = 9'(waddrs[$urandom_range(waddrs.size() - 1, 0)]);
                load(32'(a), 1'b1, 1'b0);
                load($urandom, 1'b0, 1'b1);
                run_op(1'b1, 1'b0, 1'b0);
            end
        end

        // Clear asserted in the middle of a read
        load(32'h0000_0155, 1'b1, 1'b1);
        rd = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
        @(posedge clk);
        #1;
        chk("midrd_rden_on", 32'(rden), 32'd3);
        chk("midrd_no_done", 32'(done), 32'd0);
        @(negedge clk);
        clear = 1'b1;
        #1;
        chk("clr_rden_async", 32'(rden), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("clr_mdr%0d", i), mdr[i], 32'd0);
            chk($sformatf("clr_mar%0d", i), 32'(mar[i]), 32'd0);
        end
        for (int c = 0; c < 4; c++) begin
            if (c == 2) begin
                @(negedge clk);
                clear = 1'b0;
            end
            @(posedge clk);
            #1;
            chk($sformatf("clr_done_c%0d", c), 32'(done), 32'd0);
            chk($sformatf("clr_idle_c%0d", c), 32'(busy | rden), 32'd0);
        end
        chk("clr_mdr_final", mdr[1], 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
